// File: rtl/mem_port_arbiter.sv
// Shares one single-port 16-bit memory between the fetch and data ports, and issues the dump on halt.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the data port has fixed priority.
module mem_port_arbiter #(
    parameter int ALIGN_CHECK  = 1,
    parameter int DUMP_ON_HALT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_done,
    output logic        if_err,
    output logic [15:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic        dm_done,
    output logic        dm_err,
    output logic [15:0] dm_rdata,
    input  logic        halt,
    output logic        halted,
    output logic        busy,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mem_createdump
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ACCESS = 3'd1;
    localparam logic [2:0] RESP   = 3'd2;
    localparam logic [2:0] DUMP   = 3'd3;
    localparam logic [2:0] HALTED = 3'd4;

    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    logic [2:0]  state;
    logic        owner;
    logic [15:0] lat_addr;
    logic        lat_wr;
    logic [15:0] lat_wdata;
    logic        any_req;
    logic        grant_data;
    logic        misaligned;
    logic        in_access;
    logic        in_resp;

    assign any_req    = if_req | dm_req;
    assign misaligned = (ALIGN_CHECK != 0) && lat_addr[0];

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_owner;

    // On a conflict the port that did not get the previous grant wins.
    assign grant_data = dm_req & (~if_req | (last_owner == OWNER_FETCH));

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= OWNER_FETCH;
        end else if (state == IDLE && any_req) begin
            last_owner <= grant_data;
        end
    end
`else
    assign grant_data = dm_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWNER_FETCH;
            lat_addr  <= '0;
            lat_wr    <= 1'b0;
            lat_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= ACCESS;
                        owner     <= grant_data;
                        lat_addr  <= grant_data ? dm_addr : if_addr;
                        lat_wr    <= grant_data & dm_wr;
                        lat_wdata <= grant_data ? dm_wdata : 16'h0000;
                    end else if (halt) begin
                        state <= (DUMP_ON_HALT != 0) ? DUMP : HALTED;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    // Read data is held in the owner's register until its next read completes.
                    if (!lat_wr && !misaligned) begin
                        if (owner == OWNER_DATA) begin
                            dm_rdata <= mem_rdata;
                        end else begin
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                RESP:    state <= IDLE;
                DUMP:    state <= HALTED;
                HALTED:  state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_access = (state == ACCESS);
    assign in_resp   = (state == RESP);

    // Reset gates the enable combinationally so an aborted write never reaches the array.
    assign mem_enable     = in_access & ~misaligned & ~rst;
    assign mem_wr         = mem_enable & lat_wr;
    assign mem_addr       = in_access ? lat_addr : 16'h0000;
    assign mem_wdata      = (in_access && lat_wr) ? lat_wdata : 16'h0000;
    assign mem_createdump = (state == DUMP);

    assign if_done = in_resp & (owner == OWNER_FETCH);
    assign dm_done = in_resp & (owner == OWNER_DATA);
    assign if_err  = if_done & misaligned;
    assign dm_err  = dm_done & misaligned;
    assign halted  = (state == HALTED);
    assign busy    = (state != IDLE);

endmodule
